// File: rtl/branch_resolve_ctrl.sv
// D-stage branch controller: forwards comparator operands, detects operand hazards,
// picks the comparator flag for the decoded branch and keeps delay-slot/stall statistics.
module branch_resolve_ctrl #(
   parameter int CNT_W     = 32,
   parameter int MAX_STALL = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       d_br_type,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [31:0]      rf_rd1,
   input  logic [31:0]      rf_rd2,
   input  logic [4:0]       e_wa,
   input  logic [1:0]       e_tnew,
   input  logic [31:0]      e_wd,
   input  logic [4:0]       m_wa,
   input  logic [1:0]       m_tnew,
   input  logic [31:0]      m_wd,
   input  logic             ext_stall,
   input  logic [5:0]       cmp_flags,
   output logic [31:0]      cmp_in1,
   output logic [31:0]      cmp_in2,
   output logic             br_stall,
   output logic             br_taken,
   output logic             ds_flag,
   output logic             stall_err,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int RUN_W = $clog2(MAX_STALL + 2);

   typedef enum logic {IDLE, STALL} state_t;

   state_t           state, state_n;
   logic [RUN_W-1:0] run_cnt;
   logic             br_v, rt_used, hz_rs, hz_rt, res, flag_sel, advance;

   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf,
                                       input logic [4:0] ewa, input logic [1:0] etn,
                                       input logic [31:0] ewd, input logic [4:0] mwa,
                                       input logic [1:0] mtn, input logic [31:0] mwd);
      if (r == 5'd0)                     return 32'd0;
      else if (r == ewa && etn == 2'd0)  return ewd;
      else if (r == mwa && mtn == 2'd0)  return mwd;
      else                               return rf;
   endfunction

   // A ready E result shadows a pending M write to the same register.
   function automatic logic hazard(input logic [4:0] r, input logic [4:0] ewa,
                                   input logic [1:0] etn, input logic [4:0] mwa,
                                   input logic [1:0] mtn);
      return (r != 5'd0) &&
             ((r == ewa && etn != 2'd0) ||
              (r == mwa && mtn != 2'd0 && !(r == ewa && etn == 2'd0)));
   endfunction

   assign cmp_in1 = fwd(d_rs, rf_rd1, e_wa, e_tnew, e_wd, m_wa, m_tnew, m_wd);
   assign cmp_in2 = fwd(d_rt, rf_rd2, e_wa, e_tnew, e_wd, m_wa, m_tnew, m_wd);

   assign br_v    = (d_br_type != 3'd0) && (d_br_type != 3'd7);
   assign rt_used = (d_br_type == 3'd1) || (d_br_type == 3'd2);
   assign hz_rs   = hazard(d_rs, e_wa, e_tnew, m_wa, m_tnew);
   assign hz_rt   = hazard(d_rt, e_wa, e_tnew, m_wa, m_tnew);

   assign br_stall = br_v & (hz_rs | (rt_used & hz_rt));
   assign advance  = ~br_stall & ~ext_stall;
   assign res      = br_v & advance;

   always_comb begin
      flag_sel = 1'b0;
      case (d_br_type)
         3'd1:    flag_sel = cmp_flags[0];
         3'd2:    flag_sel = cmp_flags[1];
         3'd3:    flag_sel = cmp_flags[2];
         3'd4:    flag_sel = cmp_flags[3];
         3'd5:    flag_sel = cmp_flags[4];
         3'd6:    flag_sel = cmp_flags[5];
         default: flag_sel = 1'b0;
      endcase
   end

   assign br_taken = res & flag_sel;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (br_stall)  state_n = STALL;
         STALL:   if (!br_stall) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // run_cnt caps one past MAX_STALL; the error is already latched by then.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt   <= '0;
         stall_err <= 1'b0;
         ds_flag   <= 1'b0;
      end else begin
         if (!br_stall)                             run_cnt <= '0;
         else if (run_cnt <= RUN_W'(MAX_STALL))     run_cnt <= run_cnt + 1'b1;
         if (br_stall && run_cnt == RUN_W'(MAX_STALL)) stall_err <= 1'b1;
         if (advance)                               ds_flag <= br_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         br_cnt    <= '0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (res && br_cnt != '1)         br_cnt    <= br_cnt + 1'b1;
         if (br_taken && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
         if (br_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Table-driven bench for branch_resolve_ctrl: combinational outputs checked against
// each vector, registered outputs against a queue filled by a small reference model.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  d_br_type;
   logic [4:0]  d_rs, d_rt, e_wa, m_wa;
   logic [31:0] rf_rd1, rf_rd2, e_wd, m_wd;
   logic [1:0]  e_tnew, m_tnew;
   logic        ext_stall;
   logic [5:0]  cmp_flags;
   logic [31:0] cmp_in1, cmp_in2;
   logic        br_stall, br_taken, ds_flag, stall_err;
   logic [31:0] br_cnt, taken_cnt, stall_cnt;

   branch_resolve_ctrl #(.CNT_W(32), .MAX_STALL(2)) dut (
      .clk(clk), .reset(reset), .d_br_type(d_br_type), .d_rs(d_rs), .d_rt(d_rt),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .e_wa(e_wa), .e_tnew(e_tnew), .e_wd(e_wd),
      .m_wa(m_wa), .m_tnew(m_tnew), .m_wd(m_wd), .ext_stall(ext_stall),
      .cmp_flags(cmp_flags), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2),
      .br_stall(br_stall), .br_taken(br_taken), .ds_flag(ds_flag),
      .stall_err(stall_err), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
      .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  t;
      logic [4:0]  rs, rt;
      logic [31:0] rd1, rd2;
      logic [4:0]  ewa;
      logic [1:0]  etn;
      logic [31:0] ewd;
      logic [4:0]  mwa;
      logic [1:0]  mtn;
      logic [31:0] mwd;
      logic        ext;
      logic [5:0]  flags;
      logic [31:0] x1, x2;
      logic        xs, xt;
   } vec_t;

   typedef struct packed {
      logic        ds, err;
      logic [31:0] br, tk, st;
   } reg_t;

   vec_t vt[$];
   reg_t sb[$];
   int   checks = 0, failures = 0;
   logic        m_ds, m_err;
   logic [31:0] m_br, m_tk, m_st;
   int          m_run;

   function automatic vec_t mk(input logic [2:0] t, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [4:0] ewa, input logic [1:0] etn, input logic [31:0] ewd,
                               input logic [4:0] mwa, input logic [1:0] mtn, input logic [31:0] mwd,
                               input logic ext, input logic [5:0] flags,
                               input logic [31:0] x1, input logic [31:0] x2,
                               input logic xs, input logic xt);
      vec_t v;
      v.t = t; v.rs = rs; v.rt = rt; v.rd1 = rd1; v.rd2 = rd2;
      v.ewa = ewa; v.etn = etn; v.ewd = ewd; v.mwa = mwa; v.mtn = mtn; v.mwd = mwd;
      v.ext = ext; v.flags = flags; v.x1 = x1; v.x2 = x2; v.xs = xs; v.xt = xt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      d_br_type = v.t; d_rs = v.rs; d_rt = v.rt; rf_rd1 = v.rd1; rf_rd2 = v.rd2;
      e_wa = v.ewa; e_tnew = v.etn; e_wd = v.ewd; m_wa = v.mwa; m_tnew = v.mtn;
      m_wd = v.mwd; ext_stall = v.ext; cmp_flags = v.flags;
   endtask

   task automatic check_regs(input string tag);
      reg_t e;
      e = sb.pop_front();
      chk($sformatf("%s.ds_flag", tag),   {31'd0, ds_flag},   {31'd0, e.ds});
      chk($sformatf("%s.stall_err", tag), {31'd0, stall_err}, {31'd0, e.err});
      chk($sformatf("%s.br_cnt", tag),    br_cnt,    e.br);
      chk($sformatf("%s.taken_cnt", tag), taken_cnt, e.tk);
      chk($sformatf("%s.stall_cnt", tag), stall_cnt, e.st);
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic apply(input vec_t v, input string tag);
      logic rs_ok;
      drive(v);
      #2;
      chk($sformatf("%s.cmp_in1", tag),  cmp_in1, v.x1);
      chk($sformatf("%s.cmp_in2", tag),  cmp_in2, v.x2);
      chk($sformatf("%s.br_stall", tag), {31'd0, br_stall}, {31'd0, v.xs});
      chk($sformatf("%s.br_taken", tag), {31'd0, br_taken}, {31'd0, v.xt});
      rs_ok = (v.t >= 3'd1) && (v.t <= 3'd6) && !v.xs && !v.ext;
      if (v.xs && m_run == 2) m_err = 1'b1;
      m_run = v.xs ? ((m_run < 3) ? m_run + 1 : m_run) : 0;
      if (!v.xs && !v.ext) m_ds = v.xt;
      if (rs_ok) m_br++;
      if (v.xt)  m_tk++;
      if (v.xs)  m_st++;
      sb.push_back('{m_ds, m_err, m_br, m_tk, m_st});
      @(posedge clk); #1;
      check_regs(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      m_ds = 0; m_err = 0; m_br = 0; m_tk = 0; m_st = 0; m_run = 0;
      sb.push_back('{m_ds, m_err, m_br, m_tk, m_st});
      @(posedge clk); #1;
      reset = 1'b0;
      check_regs(tag);
   endtask

   initial begin
      vec_t idle, st;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0, 0);
      st   = mk(1, 8, 0, 'h88, 'h0, 8, 1, 'h1, 0, 0, 0, 0, 6'b000001, 'h88, 0, 1, 0);
      // beq taken, then bne stalled on E and released by forwarding
      vt.push_back(mk(1, 5, 5, 'h1234, 'h1234, 0, 0, 0, 0, 0, 0, 0, 6'b101001, 'h1234, 'h1234, 0, 1));
      vt.push_back(mk(2, 8, 9, 'h11, 'h22, 8, 1, 'h99, 9, 0, 'h5A, 0, 6'b000010, 'h11, 'h5A, 1, 0));
      vt.push_back(mk(2, 8, 9, 'h11, 'h22, 8, 0, 'h7, 9, 0, 'h5A, 0, 6'b000010, 'h7, 'h5A, 0, 1));
      // bgtz on r0: no hazard even though E writes r0
      vt.push_back(mk(4, 0, 0, 'h55, 'h66, 0, 2, 'h77, 0, 0, 0, 0, 6'b100100, 0, 0, 0, 0));
      // E over M priority, then E not ready stalls even with M ready
      vt.push_back(mk(1, 3, 0, 'h1, 'h2, 3, 0, 'hA, 3, 0, 'hB, 0, 6'b000001, 'hA, 0, 0, 1));
      vt.push_back(mk(1, 3, 0, 'h1, 'h2, 3, 1, 'hA, 3, 0, 'hB, 0, 6'b000001, 'hB, 0, 1, 0));
      vt.push_back(mk(2, 3, 0, 'h1, 'h2, 3, 0, 'hA, 3, 1, 'hB, 0, 6'b000000, 'hA, 0, 0, 0));
      // blez ignores an rt hazard; type 7 ignores an rs hazard
      vt.push_back(mk(3, 1, 4, 'h31, 'h44, 4, 1, 'hEE, 0, 0, 0, 0, 6'b000100, 'h31, 'h44, 0, 1));
      vt.push_back(mk(7, 2, 0, 'h21, 'h0, 2, 1, 'hEE, 0, 0, 0, 0, 6'b111111, 'h21, 0, 0, 0));
      vt.push_back(mk(6, 6, 0, 'h60, 'h0, 0, 0, 0, 0, 0, 0, 0, 6'b100000, 'h60, 0, 0, 1));
      // bltz held by ext_stall for two cycles, then resolves once
      vt.push_back(mk(5, 7, 0, 'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b010000, 'hFFFF0000, 0, 0, 0));
      vt.push_back(mk(5, 7, 0, 'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b010000, 'hFFFF0000, 0, 0, 0));
      vt.push_back(mk(5, 7, 0, 'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b010000, 'hFFFF0000, 0, 0, 1));
      // M hazard together with ext_stall still counts a stall cycle
      vt.push_back(mk(2, 9, 0, 'h9, 0, 0, 0, 0, 9, 2, 'hCC, 1, 6'b000010, 'h9, 0, 1, 0));
      vt.push_back(idle);

      drive(idle);
      reset = 1'b1;
      @(posedge clk); #1;
      do_reset("reset0");

      foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

      // three-cycle stall run raises the sticky error
      for (int i = 0; i < 3; i++) apply(st, $sformatf("run%0d", i));
      apply(idle, "sticky");
      do_reset("reset1");

      // reset mid-stall clears the run, so two more stall cycles stay legal
      apply(st, "mid0");
      apply(st, "mid1");
      do_reset("reset2");
      apply(st, "post0");
      apply(st, "post1");
      apply(idle, "post2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- D-stage controller that sequences the branch comparator.
- Selects forwarded operands for the comparator and decides hazard stalls on those operands.
- Picks the comparator flag for the decoded branch and issues the taken decision to NPC.
- Tracks delay-slot status, stall-run length and branch statistics.
- Sits between decode, the forwarding network, the comparator and NPC.

Parameters:
- CNT_W, 32, width of statistics counters (saturating)
- MAX_STALL, 2, longest legal consecutive stall run on a branch

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- d_br_type  input  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- d_rs  input  5  rs register address of the D instruction
- d_rt  input  5  rt register address of the D instruction
- rf_rd1  input  32  register file read data for rs
- rf_rd2  input  32  register file read data for rt
- e_wa  input  5  E-stage destination register
- e_tnew  input  2  E-stage cycles until result is ready
- e_wd  input  32  E-stage result
- m_wa  input  5  M-stage destination register
- m_tnew  input  2  M-stage cycles until result is ready
- m_wd  input  32  M-stage result
- ext_stall  input  1  stall raised by another unit this cycle
- cmp_flags  input  6  comparator flags {bgez, bltz, bgtz, blez, bne, beq}
- cmp_in1  output  32  comparator operand 1 (forwarded rs)
- cmp_in2  output  32  comparator operand 2 (forwarded rt)
- br_stall  output  1  branch operand hazard; freezes F/D and bubbles E
- br_taken  output  1  branch resolved taken this cycle
- ds_flag  output  1  registered; D instruction is the delay slot of a taken branch
- stall_err  output  1  sticky; stall run exceeded MAX_STALL
- br_cnt  output  CNT_W  number of resolved branches
- taken_cnt  output  CNT_W  number of taken branches
- stall_cnt  output  CNT_W  total branch stall cycles

Behaviour:
- Branch validity: br_v = (d_br_type in 1..6).
- rt is used only for beq and bne. rs is used by every valid branch type.
- Forwarding, per operand (address r; rs to cmp_in1, rt to cmp_in2):
  - r==0 gives 0.
  - Else if r==e_wa and e_tnew==0, use e_wd.
  - Else if r==m_wa and m_tnew==0, use m_wd.
  - Else use rf_rd*.
  - Forwarding is purely combinational and does not depend on br_v.
- Hazard on a used operand r!=0:
  - Hazard if (r==e_wa and e_tnew!=0).
  - Hazard if (r==m_wa and m_tnew!=0 and not (r==e_wa and e_tnew==0)).
  - Register 0 never causes a hazard.
- br_stall = br_v & hazard. This output is combinational.
- Resolve cycle: res = br_v & !br_stall & !ext_stall.
- br_taken = res & cmp_flags[d_br_type-1]. This output is combinational, same cycle.
- FSM, 2 states, registered:
  - IDLE to STALL when br_stall.
  - STALL stays in STALL while br_stall.
  - STALL to IDLE when !br_stall.
- run_cnt (internal):
  - Increments each cycle br_stall=1.
  - Clears when br_stall=0.
  - stall_err is set when br_stall=1 and run_cnt==MAX_STALL; it is sticky until reset.
- ds_flag:
  - Next value is br_taken when D advances (!br_stall & !ext_stall).
  - Otherwise it holds its value.
- Counters, updated on the clock edge:
  - br_cnt increments when res=1.
  - taken_cnt increments when br_taken=1.
  - stall_cnt increments when br_stall=1.
  - All counters saturate at all-ones and do not wrap.
- ext_stall with a branch and no hazard:
  - No resolve and no counting.
  - br_taken=0.
  - The branch resolves later, when ext_stall drops.
- br_stall and ext_stall together: stall_cnt still counts.
- Back-to-back branches: each branch resolves and is counted once.
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - run_cnt, ds_flag, stall_err and all counters go to 0.
  - Combinational outputs follow their inputs immediately.
  - A reset asserted mid-stall clears the stall run; no error is raised.

Test Plan:
1. beq, rs=rt=5, no hazards, rf_rd1=rf_rd2=0x1234, cmp_flags=6'b101001:
   - Same cycle: br_taken=1, br_stall=0.
   - Next edge: br_cnt=1, taken_cnt=1, ds_flag=1.
2. bne with rs=8, e_wa=8, e_tnew=1:
   - br_stall=1 for the first cycle.
   - Drop e_tnew to 0 with e_wd=7: cmp_in1=7, br_stall=0, resolve.
   - stall_cnt=1, FSM returns to IDLE.
3. bgtz with rs=0 and e_wa=0, e_tnew=2:
   - No stall, cmp_in1=0.
   - cmp_flags from a real comparator gives bgtz=0, so br_taken=0.
4. Priority: rs=3 with e_wa=3, e_tnew=0, e_wd=0xA and m_wa=3, m_tnew=0, m_wd=0xB:
   - cmp_in1=0xA.
   - Same with e_tnew=1: br_stall=1 even though M is ready.
5. Hold br_stall=1 for 3 cycles (MAX_STALL=2):
   - stall_err rises after the 3rd stall cycle and stays 1.
   - Synchronous reset clears stall_err and all counters to 0.
6. bltz with ext_stall=1 for 2 cycles, no hazard:
   - br_taken=0 and br_cnt unchanged during those cycles.
   - When ext_stall drops: resolves once, br_cnt increments by exactly 1.
   - Also check blez, bgez and type 7; type 7 gives no stall, no taken, no count.
